// File: rtl/multiplicador_secuencial_n.sv
`default_nettype none
// ============================================================================
//  Module   : multiplicador_secuencial_n (with helper sumadorCompletoN)
//  Purpose  : Iterative radix-2 shift-and-add multiplier, one partial product
//             per clock, unsigned or two's-complement operands, full
//             2*WIDTH-bit product, start/done handshake.
//  Ports    : clk           rising-edge clock
//             rst_n         asynchronous active-low reset
//             start         request, sampled only in IDLE
//             con_signo     1 = two's-complement operands, 0 = unsigned
//             multiplicando operand A (WIDTH bits), captured with start
//             multiplicador operand B (WIDTH bits), captured with start
//             busy          high in CALC and FIN
//             done          one-cycle pulse in FIN; res valid from then on
//             res           product (2*WIDTH bits), held until next completion
//  Revision : 1.0 - initial release
// ============================================================================

// Ripple-carry N-bit adder; the single accumulation resource of the multiplier.
module sumadorCompletoN #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);
    logic [N:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[N];
endmodule

module multiplicador_secuencial_n #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               con_signo,
    input  logic [WIDTH-1:0]   multiplicando,
    input  logic [WIDTH-1:0]   multiplicador,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] res
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [WIDTH:0]     r_acc_hi;   // upper partial product incl. carry bit
    logic [WIDTH-1:0]   r_acc_lo;   // multiplier bits, replaced by product LSBs
    logic [WIDTH-1:0]   r_mcand;
    logic [CW-1:0]      r_cuenta;
    logic               r_signo;
    logic [2*WIDTH-1:0] r_res;

    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic [WIDTH:0]     w_sum_full;
    logic [2*WIDTH-1:0] w_prod_mag;
    logic [2*WIDTH-1:0] w_res_next;
    logic               w_last;

    // Magnitudes; -2^(WIDTH-1) negates to itself, which reads correctly as
    // an unsigned magnitude.
    assign w_a_abs = (con_signo && multiplicando[WIDTH-1]) ? -multiplicando : multiplicando;
    assign w_b_abs = (con_signo && multiplicador[WIDTH-1]) ? -multiplicador : multiplicador;

    sumadorCompletoN #(
        .N (WIDTH)
    ) u_sumador (
        .a    (r_acc_hi[WIDTH-1:0]),
        .b    (r_mcand),
        .cin  (1'b0),
        .s    (w_sum),
        .cout (w_cout)
    );

    assign w_sum_full = r_acc_lo[0] ? {w_cout, w_sum} : r_acc_hi;

    // Product after the final shift: the shifted-out MSB is always zero,
    // so the low 2*WIDTH bits carry the whole magnitude.
    assign w_prod_mag = {w_sum_full, r_acc_lo[WIDTH-1:1]};
    assign w_res_next = r_signo ? -w_prod_mag : w_prod_mag;   // -0 == 0
    assign w_last     = (r_cuenta == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = CALC;
            CALC:    if (w_last) w_next_state = FIN;
            FIN:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_mcand  <= '0;
            r_cuenta <= '0;
            r_signo  <= 1'b0;
            r_res    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc_hi <= '0;
                        r_acc_lo <= w_b_abs;
                        r_mcand  <= w_a_abs;
                        r_cuenta <= '0;
                        r_signo  <= con_signo & (multiplicando[WIDTH-1] ^ multiplicador[WIDTH-1]);
                    end
                end
                CALC: begin
                    r_acc_hi <= {1'b0, w_sum_full[WIDTH:1]};
                    r_acc_lo <= {w_sum_full[0], r_acc_lo[WIDTH-1:1]};
                    r_cuenta <= r_cuenta + CW'(1);
                    if (w_last) begin
                        r_res <= w_res_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == CALC) || (r_state == FIN);
    assign done = (r_state == FIN);
    assign res  = r_res;
endmodule
`default_nettype wire

// File: tb/tb_multiplicador_secuencial_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multiplicador_secuencial_n
//  Purpose  : Directed self-checking bench for multiplicador_secuencial_n
//             at WIDTH=4: hand-computed vectors, handshake, reset, sweep.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multiplicador_secuencial_n;
    localparam int WIDTH = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               con_signo;
    logic [WIDTH-1:0]   multiplicando;
    logic [WIDTH-1:0]   multiplicador;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] res;

    int errors = 0;
    int checks = 0;

    multiplicador_secuencial_n #(
        .WIDTH (WIDTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .con_signo     (con_signo),
        .multiplicando (multiplicando),
        .multiplicador (multiplicador),
        .busy          (busy),
        .done          (done),
        .res           (res)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b, input logic sg);
        int sa;
        int sb;
        sa = sg ? int'($signed(a)) : int'(a);
        sb = sg ? int'($signed(b)) : int'(b);
        return 8'(sa * sb);
    endfunction

    // One operation. Operands are scrambled right after capture. Samples on
    // negedges; lat = index of the edge after E0 at which done is sampled.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic sg,
                          input logic pulse, output logic [7:0] r, output int lat,
                          output int busy_cnt, output int done_cnt);
        lat = 0; busy_cnt = 0; done_cnt = 0; r = 'x;
        @(negedge clk);
        multiplicando = a; multiplicador = b; con_signo = sg; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                multiplicando = ~a; multiplicador = a ^ b; con_signo = ~sg;
            end
            if (pulse && (k == 2 || k == 5)) start = 1'b1;
            if (pulse && (k == 3 || k == 6)) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat == 0) begin
                    lat = k;
                    r = res;
                end
            end
            if (lat != 0 && k >= lat + 2) break;
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sg;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[7] = '{
        '{4'h8, 4'h8, 1'b1, 8'h40},   // -8 x -8
        '{4'hD, 4'h5, 1'b1, 8'hF1},   // -3 x 5
        '{4'h7, 4'h8, 1'b1, 8'hC8},   // 7 x -8
        '{4'h0, 4'hB, 1'b1, 8'h00},   // 0 x -5
        '{4'hF, 4'hF, 1'b0, 8'hE1},   // 15 x 15
        '{4'h0, 4'hF, 1'b0, 8'h00},   // 0 x 15
        '{4'h8, 4'h8, 1'b0, 8'h40}    // 8 x 8 unsigned
    };

    initial begin
        logic [7:0] r;
        int lat, bcnt, dcnt;
        int d1, d2, d3, nd, seen;

        rst_n = 1'b0; start = 1'b0; con_signo = 1'b0;
        multiplicando = '0; multiplicador = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_res",  32'(res),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Unsigned basic 13 x 11
        run_op(4'd13, 4'd11, 1'b0, 1'b0, r, lat, bcnt, dcnt);
        check("u13x11_res",  32'(r),    32'h8F);
        check("u13x11_lat",  32'(lat),  32'd5);
        check("u13x11_done", 32'(dcnt), 32'd1);
        check("u13x11_busy", 32'(bcnt), 32'd5);

        // Directed corners
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sg, 1'b0, r, lat, bcnt, dcnt);
            check($sformatf("vec%0d_res", i), 32'(r), 32'(vecs[i].exp));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd5);
        end

        // res holds between operations (last product 0x40)
        repeat (5) @(negedge clk);
        check("hold_res", 32'(res), 32'h40);

        // start pulses during CALC/FIN are not queued
        run_op(4'd3, 4'd6, 1'b0, 1'b1, r, lat, bcnt, dcnt);
        check("pulse_res",  32'(r),    32'd18);
        check("pulse_done", 32'(dcnt), 32'd1);
        @(negedge clk);
        check("pulse_idle", 32'(busy), 32'd0);

        // start held high: one product every 6 cycles
        @(negedge clk);
        multiplicando = 4'd3; multiplicador = 4'd5; con_signo = 1'b0; start = 1'b1;
        @(posedge clk);
        d1 = 0; d2 = 0; d3 = 0; nd = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                if (nd == 1) d1 = k;
                if (nd == 2) d2 = k;
                if (nd == 3) begin
                    d3 = k;
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        check("held_first",  32'(d1), 32'd5);
        check("held_period", 32'(d2 - d1), 32'd6);
        check("held_period2", 32'(d3 - d2), 32'd6);
        check("held_res",    32'(res), 32'd15);
        repeat (3) @(negedge clk);
        check("held_stop", 32'(busy), 32'd0);

        // Asynchronous reset in cycle 2 of CALC
        @(negedge clk);
        multiplicando = 4'd7; multiplicador = 4'd7; con_signo = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_res",  32'(res),  32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("rst_no_done", 32'(seen), 32'd0);
        run_op(4'd7, 4'd7, 1'b0, 1'b0, r, lat, bcnt, dcnt);
        check("rst_after_res", 32'(r), 32'd49);

        // Exhaustive sweep, both modes
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    run_op(4'(a), 4'(b), 1'(s), 1'b0, r, lat, bcnt, dcnt);
                    check($sformatf("sw_s%0d_%0dx%0d", s, a, b), 32'(r),
                          32'(ref_mul(4'(a), 4'(b), 1'(s))));
                    check($sformatf("sw_lat_s%0d_%0dx%0d", s, a, b), 32'(lat), 32'd5);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
